// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: HEADER, CMD, LEN, LEN payload bytes, optional CHK byte.
// Define FRAME_CHKSUM_EN to expect and verify the trailing checksum byte.
module uart_frame_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned TIMEOUT_CYC = 1041600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 frame_valid,
    output logic [7:0]           frame_cmd,
    output logic [3:0]           frame_len,
    output logic [8*MAX_LEN-1:0] frame_payload,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy
);
    localparam int unsigned LEN_W = 4;
    localparam int unsigned PL_W  = 8 * MAX_LEN;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ERR_LEN = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;
`ifdef FRAME_CHKSUM_EN
    localparam logic [1:0] ERR_CHK = 2'b01;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD
`ifdef FRAME_CHKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t            state;
    logic [7:0]        cmd_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  idx;
    logic [PL_W-1:0]   shadow;
    logic [PL_W-1:0]   shadow_ins;
    logic [CNT_W-1:0]  tcnt;
    logic              tmo_hit;
`ifdef FRAME_CHKSUM_EN
    logic [7:0]        chk;
`endif

    // Shadow buffer with the current byte dropped into slot idx.
    always_comb begin
        shadow_ins = shadow;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == LEN_W'(i)) shadow_ins[8*i +: 8] = in_data;
        end
    end

    assign tmo_hit = (state != S_IDLE) && (tcnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            cmd_r         <= '0;
            len_r         <= '0;
            idx           <= '0;
            shadow        <= '0;
            tcnt          <= '0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= '0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
`ifdef FRAME_CHKSUM_EN
            chk           <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            tcnt        <= (in_valid || state == S_IDLE) ? '0 : tcnt + CNT_W'(1);

            if (in_valid) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == HEADER) begin
                            state  <= S_CMD;
                            busy   <= 1'b1;
                            shadow <= '0;
                            idx    <= '0;
`ifdef FRAME_CHKSUM_EN
                            chk    <= '0;
`endif
                        end
                    end
                    S_CMD: begin
                        cmd_r <= in_data;
                        state <= S_LEN;
`ifdef FRAME_CHKSUM_EN
                        chk   <= in_data;
`endif
                    end
                    S_LEN: begin
                        if (in_data > 8'(MAX_LEN)) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                        end else begin
                            len_r <= in_data[LEN_W-1:0];
`ifdef FRAME_CHKSUM_EN
                            chk   <= chk + in_data;
                            state <= (in_data == 8'd0) ? S_CHK : S_PAYLOAD;
`else
                            // Empty frame is complete on its LEN byte.
                            if (in_data == 8'd0) begin
                                state         <= S_IDLE;
                                busy          <= 1'b0;
                                frame_valid   <= 1'b1;
                                frame_cmd     <= cmd_r;
                                frame_len     <= '0;
                                frame_payload <= '0;
                            end else begin
                                state <= S_PAYLOAD;
                            end
`endif
                        end
                    end
                    S_PAYLOAD: begin
                        shadow <= shadow_ins;
                        idx    <= idx + LEN_W'(1);
`ifdef FRAME_CHKSUM_EN
                        chk    <= chk + in_data;
                        if (idx == len_r - LEN_W'(1)) state <= S_CHK;
`else
                        if (idx == len_r - LEN_W'(1)) begin
                            state         <= S_IDLE;
                            busy          <= 1'b0;
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_r;
                            frame_len     <= len_r;
                            frame_payload <= shadow_ins;
                        end
`endif
                    end
`ifdef FRAME_CHKSUM_EN
                    S_CHK: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (in_data == chk) begin
                            frame_valid   <= 1'b1;
                            frame_cmd     <= cmd_r;
                            frame_len     <= len_r;
                            frame_payload <= shadow;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (tmo_hit) begin
                // A byte arriving in the expiry cycle wins over the timeout.
                state     <= S_IDLE;
                busy      <= 1'b0;
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized self-checking bench for uart_frame_parser against a frame-level reference model.
// Follows FRAME_CHKSUM_EN the same way the design does.
module tb_uart_frame_parser;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TO      = 40;
    localparam logic [7:0]  HDR     = 8'hAA;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 frame_valid;
    logic [7:0]           frame_cmd;
    logic [3:0]           frame_len;
    logic [8*MAX_LEN-1:0] frame_payload;
    logic                 frame_err;
    logic [1:0]           err_code;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: last accepted frame and last abort cause.
    logic [7:0]           exp_cmd;
    logic [3:0]           exp_len;
    logic [8*MAX_LEN-1:0] exp_payload;
    logic [1:0]           exp_code;

    uart_frame_parser #(
        .HEADER      (HDR),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send one frame, predict its outcome from the frame rules, check every byte and the result.
    task automatic run_frame(input logic [7:0] cmd, input int len, input logic [63:0] pl,
                             input bit corrupt, input int gap_max, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bit         good;
        logic [1:0] code;
        bytes = {HDR, cmd, 8'(len)};
        sum   = 8'(cmd + 8'(len));
        good  = 1'b0;
        code  = 2'b10;
        if (len <= int'(MAX_LEN)) begin
            for (int i = 0; i < len; i++) begin
                bytes.push_back(pl[8*i +: 8]);
                sum = 8'(sum + pl[8*i +: 8]);
            end
`ifdef FRAME_CHKSUM_EN
            bytes.push_back(corrupt ? 8'(sum + 8'($urandom_range(1, 255))) : sum);
            good = !corrupt;
            code = 2'b01;
`else
            good = 1'b1;
`endif
        end
        for (int k = 0; k < bytes.size(); k++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            drive_byte(bytes[k]);
            if (k != bytes.size() - 1) begin
                checks++;
                if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_pulse byte%0d: valid=%b err=%b required 0/0",
                             tag, k, frame_valid, frame_err);
                end
            end
        end
        if (good) begin
            exp_cmd     = cmd;
            exp_len     = 4'(len);
            exp_payload = '0;
            for (int i = 0; i < len; i++) exp_payload[8*i +: 8] = pl[8*i +: 8];
        end else begin
            exp_code = code;
        end
        checks++;
        if (frame_valid !== good || frame_err !== !good) begin
            errors++;
            $display("FAIL %s result: valid=%b err=%b required valid=%b err=%b",
                     tag, frame_valid, frame_err, good, !good);
        end
        checks++;
        if (frame_cmd !== exp_cmd || frame_len !== exp_len || frame_payload !== exp_payload) begin
            errors++;
            $display("FAIL %s outputs: cmd=%h len=%0d pl=%h required cmd=%h len=%0d pl=%h",
                     tag, frame_cmd, frame_len, frame_payload, exp_cmd, exp_len, exp_payload);
        end
        checks++;
        if (err_code !== exp_code) begin
            errors++;
            $display("FAIL %s err_code: got %b required %b", tag, err_code, exp_code);
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after: valid=%b err=%b busy=%b required 0/0/0",
                     tag, frame_valid, frame_err, busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_cmd = '0; exp_len = '0; exp_payload = '0; exp_code = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b0 ||
            frame_cmd !== 8'h00 || frame_len !== 4'h0 || frame_payload !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b e=%b code=%b busy=%b cmd=%h len=%h pl=%h required all 0",
                     frame_valid, frame_err, err_code, busy, frame_cmd, frame_len, frame_payload);
        end
    endtask

    task automatic test_directed();
        run_frame(8'h01, 2, 64'h2010, 1'b0, 0, "good_frame");
        run_frame(8'h01, 2, 64'h2010, 1'b1, 0, "bad_chk");
        run_frame(8'h05, 0, 64'h0, 1'b0, 0, "zero_len");
        run_frame(8'h01, 9, 64'h0, 1'b0, 0, "oversize");
        drive_byte(8'h55);
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL junk_byte: valid=%b err=%b busy=%b required 0/0/0",
                     frame_valid, frame_err, busy);
        end
        run_frame(8'h07, 1, 64'h42, 1'b0, 0, "after_junk");
        run_frame(8'hAA, 8, 64'hAA01_AAAA_0203_AA04, 1'b0, 0, "header_in_payload");
    endtask

    task automatic test_random();
        logic [7:0] junk;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == HDR) junk = 8'h00;
                drive_byte(junk);
                checks++;
                if (frame_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL random_junk%0d: valid=%b err=%b busy=%b required 0/0/0",
                             n, frame_valid, frame_err, busy);
                end
            end
            run_frame(8'($urandom), $urandom_range(0, 10), {$urandom, $urandom},
                      ($urandom_range(0, 3) == 0), 3, $sformatf("random%0d", n));
        end
    endtask

    task automatic test_timeout();
        int k;
        bit seen;
        drive_byte(HDR);
        drive_byte(8'h11);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy: got %b required 1", busy);
        end
        k = 0;
        seen = 1'b0;
        while (!seen && k < int'(TO) + 10) begin
            @(negedge clk);
            k++;
            if (frame_err === 1'b1) seen = 1'b1;
        end
        exp_code = 2'b11;
        checks++;
        if (!seen || k != int'(TO)) begin
            errors++;
            $display("FAIL timeout_latency: err seen=%b after %0d cycles required 1 after %0d",
                     seen, k, TO);
        end
        checks++;
        if (err_code !== exp_code || busy !== 1'b0 || frame_valid !== 1'b0 ||
            frame_cmd !== exp_cmd || frame_len !== exp_len || frame_payload !== exp_payload) begin
            errors++;
            $display("FAIL timeout_state: code=%b busy=%b valid=%b cmd=%h required code=%b busy=0 valid=0 cmd=%h",
                     err_code, busy, frame_valid, frame_cmd, exp_code, exp_cmd);
        end
    endtask

    task automatic test_expiry_byte();
        drive_byte(HDR);
        drive_byte(8'h3C);
        repeat (TO - 2) @(negedge clk);
        drive_byte(8'h01);
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL expiry_byte: err=%b busy=%b required err=0 busy=1", frame_err, busy);
        end
        drive_byte(8'h5A);
`ifdef FRAME_CHKSUM_EN
        drive_byte(8'h97);
`endif
        exp_cmd = 8'h3C; exp_len = 4'd1; exp_payload = 64'h5A;
        checks++;
        if (frame_valid !== 1'b1 || frame_cmd !== exp_cmd || frame_len !== exp_len ||
            frame_payload !== exp_payload || err_code !== exp_code) begin
            errors++;
            $display("FAIL expiry_frame: valid=%b cmd=%h len=%0d pl=%h code=%b required 1 %h %0d %h %b",
                     frame_valid, frame_cmd, frame_len, frame_payload, err_code,
                     exp_cmd, exp_len, exp_payload, exp_code);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        drive_byte(HDR);
        drive_byte(8'h01);
        drive_byte(8'h02);
        drive_byte(8'h10);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (frame_valid !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b0 ||
            frame_cmd !== 8'h00 || frame_len !== 4'h0 || frame_payload !== '0) begin
            errors++;
            $display("FAIL midframe_reset: v=%b e=%b code=%b busy=%b cmd=%h len=%h pl=%h required all 0",
                     frame_valid, frame_err, err_code, busy, frame_cmd, frame_len, frame_payload);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cmd = '0; exp_len = '0; exp_payload = '0; exp_code = '0;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_release: err=%b valid=%b busy=%b required 0/0/0",
                     frame_err, frame_valid, busy);
        end
        run_frame(8'h01, 2, 64'h2010, 1'b0, 1, "post_reset_frame");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_expiry_byte();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
